aes_selftest_seq: RTL
=====================

# aes_selftest_seq

Parametrised self-test sequencer for the AES datapath. It drives one cipher core and one decipher core through a start/done handshake, with the key length selected at run time (AES-128/192/256). It latches both results, measures each core's latency, checks the round trip, and presents pass/fail plus a selectable result byte to the display/LED layer. It sits between the board top and the `cipherEN`/`decipherDE` cores, and replaces the fixed-count sequencing used for the single-key-size build.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles allowed per core run before the run is declared failed. Legal range 2..255.
- `LAT_W`, default 8: width of the latency counters and outputs.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle request to begin a test. Honoured only in IDLE or DONE.
- `mode` in 2: key length. 01 = 128 (Nk 4, Nr 10), 10 = 192 (Nk 6, Nr 12), 11 = 256 (Nk 8, Nr 14), 00 = invalid.
- `plaintext` in 128: test vector. Sampled when `start` is accepted.
- `key` in 256: key, MSB-aligned. Only the top 32·Nk bits are used.
- `enc_start`, `dec_start` out 1: one-cycle launch pulses to the cores.
- `core_nk` out 4: Nk for the latched mode.
- `core_nr` out 4: Nr for the latched mode.
- `core_key` out 256: latched key, with unused low bits forced to 0.
- `enc_pt` out 128: latched plaintext.
- `dec_ct` out 128: latched ciphertext.
- `enc_done`, `dec_done` in 1: core result-valid strobes.
- `enc_data`, `dec_data` in 128: core results, valid while the matching done is high.
- `disp_src` in 1: display source. 0 = ciphertext, 1 = deciphered text.
- `disp_sel` in 4: byte index. 0 selects bits [7:0].
- `disp_byte` out 8: registered selected byte.
- `busy` out 1: high in ENC, DEC and CHECK.
- `done` out 1: one-cycle pulse on entering DONE.
- `pass` out 1: test result, held in DONE.
- `timeout` out 1: timeout flag, held in DONE.
- `lat_enc`, `lat_dec` out `LAT_W`: measured core latencies.

## Operation
- States: IDLE, ENC, DEC, CHECK, DONE.
- IDLE/DONE → ENC on `start` with `mode` ≠ 00.
  - Latch `mode`, `plaintext` and masked `key`.
  - Clear `ct_reg`, `dt_reg`, `pass`, `timeout` and the latency counters.
  - `start` with `mode` = 00 is ignored; the state and all outputs are unchanged.
- ENC:
  - `enc_start` pulses in the first ENC cycle.
  - The cycle counter increments every ENC cycle after the pulse.
  - On `enc_done`: latch `enc_data` into `ct_reg` and the count into `lat_enc`, then go to DEC.
  - If the counter reaches `TIMEOUT` first: set `timeout`, go to DONE with `pass` = 0.
- DEC:
  - Same as ENC, using `dec_start`/`dec_done`/`dec_data`, with `dec_ct` = `ct_reg`.
  - Results go to `dt_reg` and `lat_dec`, then CHECK.
- CHECK: one cycle.
  - `pass` = (`dt_reg` == `pt_reg`) && (`ct_reg` != `pt_reg`).
  - Then go to DONE.
- DONE: hold all results. `start` re-arms with a full clear.
- Done strobes:
  - A done strobe in the same cycle as its start pulse is ignored.
  - Done strobes outside the matching wait state are ignored.
  - The latency counter saturates at its maximum value; it never wraps.
- `start` while `busy` is ignored. A changing `mode` or `plaintext` mid-run has no effect.
- Display: `disp_byte` = byte `disp_sel` of (`disp_src` ? `dt_reg` : `ct_reg`), registered.

## Timing
- Reset values: state IDLE, all registers 0, all outputs 0.
- Reset mid-run returns to IDLE immediately. No further start pulses are issued.
- `start` accepted in cycle t:
  - `enc_start` = 1 and `busy` = 1 in t+1.
  - `enc_done` first seen in cycle t+1+L gives `lat_enc` = L.
  - `dec_start` is asserted the cycle after `enc_done`.
- CHECK lasts exactly 1 cycle. `done` pulses in the first DONE cycle, with `pass` valid in that same cycle.
- Total run time from start to done = `lat_enc` + `lat_dec` + 4 cycles.
- `disp_byte` latency: 1 cycle from a `disp_sel`/`disp_src` change or a result-register update.
- Timeout fires in the cycle the counter equals `TIMEOUT`. `done` pulses the next cycle.

## Structure
- Shared package `aes_pkg` holds:
  - the mode encoding constants;
  - the Nk/Nr lookup for each mode;
  - the key-mask function;
  - the state encoding.
- One sub-module, `aes_run_timer`: a start/done wait with a saturating latency counter and timeout compare. It is instantiated once and shared between ENC and DEC.
- Display byte mux and compare logic stay inline.

## Test plan
- FIPS-197 AES-128: `mode` 01, pt 00112233445566778899aabbccddeeff, key 000102…0f, core bus-functional-model (BFM) latency 11.
  - Required: `ct_reg` 69c4e0d86a7b0430d8cdb78070b4c55a, `pass` = 1, `lat_enc` = 11, `done` at t+26.
- AES-192: `mode` 10, key 000102…17.
  - Required: ct dda97ca4864cdfe06eaf70a0ec0d7191, `core_nr` 12, `pass` = 1.
- AES-256: `mode` 11, key 000102…1f.
  - Required: ct 8ea2b7ca516745bfeafc49904b496089, `core_nk` 8, `pass` = 1.
- Timeout: decipher BFM never asserts done, `TIMEOUT` 64.
  - Required: `timeout` = 1, `pass` = 0, `done` 65 cycles after `dec_start`.
- Corrupted decipher output (bit 0 flipped) → `pass` = 0, `timeout` = 0.
- Corner cases:
  - `mode` 00 start → no `enc_start`.
  - `start` during DEC → ignored.
  - Reset asserted in DEC → outputs 0, IDLE.
  - `disp_sel` 0, `disp_src` 0 after the AES-128 run → `disp_byte` 5a.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared encodings for the AES self-test sequencer: key-length modes, Nk/Nr lookup,
// key masking and the sequencer state encoding.
package aes_pkg;

   localparam logic [1:0] MODE_INV = 2'b00;
   localparam logic [1:0] MODE_128 = 2'b01;
   localparam logic [1:0] MODE_192 = 2'b10;
   localparam logic [1:0] MODE_256 = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENC   = 3'd1,
      ST_DEC   = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic [3:0] mode_nk(input logic [1:0] m);
      case (m)
         MODE_128: return 4'd4;
         MODE_192: return 4'd6;
         MODE_256: return 4'd8;
         default:  return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] mode_nr(input logic [1:0] m);
      case (m)
         MODE_128: return 4'd10;
         MODE_192: return 4'd12;
         MODE_256: return 4'd14;
         default:  return 4'd0;
      endcase
   endfunction

   // The key is MSB-aligned; only the top 32*Nk bits survive.
   function automatic logic [255:0] key_mask(input logic [1:0] m, input logic [255:0] k);
      logic [255:0] keep;
      case (m)
         MODE_128: keep = {{128{1'b1}}, 128'b0};
         MODE_192: keep = {{192{1'b1}}, 64'b0};
         MODE_256: keep = {256{1'b1}};
         default:  keep = '0;
      endcase
      return k & keep;
   endfunction

endpackage

// File: rtl/aes_run_timer.sv
// Start/done wait for one core run: saturating latency counter plus timeout compare.
// Shared between the cipher and decipher phases; it restarts from 0 after every hit.
module aes_run_timer #(
   parameter int TIMEOUT = 64,
   parameter int LAT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             active,
   input  logic             first,
   input  logic             core_done,
   output logic             hit_done,
   output logic             hit_timeout,
   output logic [LAT_W-1:0] count
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   logic [LAT_W-1:0] lat_q, lat_d;
   logic [7:0]       tmo_q, tmo_d;

   always_comb begin
      // A done strobe in the launch cycle belongs to no run and is dropped.
      hit_done    = active && !first && core_done;
      hit_timeout = active && !hit_done && (tmo_q == TMO_LIMIT);
      lat_d       = lat_q;
      tmo_d       = tmo_q;
      if (!active || hit_done || hit_timeout) begin
         lat_d = '0;
         tmo_d = '0;
      end else begin
         if (lat_q != {LAT_W{1'b1}}) lat_d = lat_q + 1'b1;
         if (tmo_q != 8'hff)         tmo_d = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_q <= '0;
         tmo_q <= '0;
      end else begin
         lat_q <= lat_d;
         tmo_q <= tmo_d;
      end
   end

   assign count = lat_q;

endmodule

// File: rtl/aes_selftest_seq.sv
// Self-test sequencer: runs cipher then decipher core, measures latencies, checks the
// round trip and exposes pass/fail plus a selectable result byte for the display.
module aes_selftest_seq
   import aes_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int LAT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [127:0]     plaintext,
   input  logic [255:0]     key,
   output logic             enc_start,
   output logic             dec_start,
   output logic [3:0]       core_nk,
   output logic [3:0]       core_nr,
   output logic [255:0]     core_key,
   output logic [127:0]     enc_pt,
   output logic [127:0]     dec_ct,
   input  logic             enc_done,
   input  logic             dec_done,
   input  logic [127:0]     enc_data,
   input  logic [127:0]     dec_data,
   input  logic             disp_src,
   input  logic [3:0]       disp_sel,
   output logic [7:0]       disp_byte,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [LAT_W-1:0] lat_enc,
   output logic [LAT_W-1:0] lat_dec
);

   state_e           state_q, state_d;
   logic             first_q, first_d;
   logic [1:0]       mode_q, mode_d;
   logic [127:0]     pt_q, pt_d, ct_q, ct_d, dt_q, dt_d;
   logic [255:0]     key_q, key_d;
   logic             pass_q, pass_d, timeout_q, timeout_d, done_q, done_d;
   logic [LAT_W-1:0] lat_enc_q, lat_enc_d, lat_dec_q, lat_dec_d;
   logic [7:0]       disp_q, disp_d;
   logic [127:0]     disp_word;

   logic             t_active, t_core_done, t_hit_done, t_hit_timeout;
   logic [LAT_W-1:0] t_count;

   assign t_active    = (state_q == ST_ENC) || (state_q == ST_DEC);
   assign t_core_done = (state_q == ST_DEC) ? dec_done : enc_done;

   aes_run_timer #(.TIMEOUT(TIMEOUT), .LAT_W(LAT_W)) u_timer (
      .clk         (clk),
      .reset       (reset),
      .active      (t_active),
      .first       (first_q),
      .core_done   (t_core_done),
      .hit_done    (t_hit_done),
      .hit_timeout (t_hit_timeout),
      .count       (t_count)
   );

   always_comb begin
      // NOTE: every next value defaults to its current value first, so no branch infers a latch.
      state_d   = state_q;
      first_d   = 1'b0;
      mode_d    = mode_q;
      pt_d      = pt_q;
      key_d     = key_q;
      ct_d      = ct_q;
      dt_d      = dt_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      done_d    = 1'b0;
      lat_enc_d = lat_enc_q;
      lat_dec_d = lat_dec_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start && (mode != MODE_INV)) begin
               state_d   = ST_ENC;
               first_d   = 1'b1;
               mode_d    = mode;
               pt_d      = plaintext;
               key_d     = key_mask(mode, key);
               ct_d      = '0;
               dt_d      = '0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               lat_enc_d = '0;
               lat_dec_d = '0;
            end
         end
         ST_ENC: begin
            if (t_hit_done) begin
               ct_d      = enc_data;
               lat_enc_d = t_count;
               state_d   = ST_DEC;
               first_d   = 1'b1;
            end else if (t_hit_timeout) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
               done_d    = 1'b1;
            end
         end
         ST_DEC: begin
            if (t_hit_done) begin
               dt_d      = dec_data;
               lat_dec_d = t_count;
               state_d   = ST_CHECK;
            end else if (t_hit_timeout) begin
               timeout_d = 1'b1;
               state_d   = ST_DONE;
               done_d    = 1'b1;
            end
         end
         ST_CHECK: begin
            // A core that passes data through unchanged must not count as a pass.
            pass_d  = (dt_q == pt_q) && (ct_q != pt_q);
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      disp_word = disp_src ? dt_q : ct_q;
      disp_d    = disp_word[{disp_sel, 3'b000} +: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      // NOTE: the wide data registers are reset as well, since every output must read 0 after reset.
      if (reset) begin
         state_q   <= ST_IDLE;
         first_q   <= 1'b0;
         mode_q    <= MODE_INV;
         pt_q      <= '0;
         key_q     <= '0;
         ct_q      <= '0;
         dt_q      <= '0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
         lat_enc_q <= '0;
         lat_dec_q <= '0;
         disp_q    <= '0;
      end else begin
         state_q   <= state_d;
         first_q   <= first_d;
         mode_q    <= mode_d;
         pt_q      <= pt_d;
         key_q     <= key_d;
         ct_q      <= ct_d;
         dt_q      <= dt_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         done_q    <= done_d;
         lat_enc_q <= lat_enc_d;
         lat_dec_q <= lat_dec_d;
         disp_q    <= disp_d;
      end
   end

   assign enc_start = (state_q == ST_ENC) && first_q;
   assign dec_start = (state_q == ST_DEC) && first_q;
   assign busy      = (state_q == ST_ENC) || (state_q == ST_DEC) || (state_q == ST_CHECK);
   assign core_nk   = mode_nk(mode_q);
   assign core_nr   = mode_nr(mode_q);
   assign core_key  = key_q;
   assign enc_pt    = pt_q;
   assign dec_ct    = ct_q;
   assign disp_byte = disp_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign timeout   = timeout_q;
   assign lat_enc   = lat_enc_q;
   assign lat_dec   = lat_dec_q;

endmodule
